// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O responder:
// register offsets, status/control bit positions and the ctrl register layout.
package io_pkg;

   localparam logic [3:0] OFF_DATA   = 4'd0;
   localparam logic [3:0] OFF_STATUS = 4'd1;
   localparam logic [3:0] OFF_CTRL   = 4'd2;
   localparam logic [3:0] OFF_TLO    = 4'd3;
   localparam logic [3:0] OFF_THI    = 4'd4;

   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_FULL  = 2;
   localparam int ST_TX_OVF   = 3;
   localparam int ST_TIMER    = 5;
   localparam int ST_IRQ      = 7;

   localparam int CT_RX_IE     = 0;
   localparam int CT_TXE_IE    = 1;
   localparam int CT_TIMER_IE  = 2;
   localparam int CT_TIMER_RUN = 3;

   typedef struct packed {
      logic timer_run;
      logic timer_ie;
      logic tx_empty_ie;
      logic rx_ie;
   } ctrl_t;

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO with push/pop and head view.
// Callers must not push when full or pop when empty.
module io_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   // power-of-two depth lets the pointers wrap by natural overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O target: TX FIFO, RX holding register,
// reloading interval timer and a level interrupt request.
module io_responder
   import io_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR  = 16'hF000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        ph2,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic        read_en,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        sel,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        irq
);

   logic [3:0]  off;
   logic        bus_wr;
   logic        bus_rd;
   logic        hit_data;
   logic        hit_status;
   logic        hit_ctrl;
   logic        hit_tlo;
   logic        hit_thi;

   logic        tx_full;
   logic        tx_empty;
   logic        push_req;
   logic        push;
   logic        pop;

   logic        rx_full;
   logic [7:0]  rx_hold;
   logic        tx_ovf;
   logic        timer_flag;
   ctrl_t       ctrl;
   logic [15:0] reload;
   logic [15:0] count;
   logic [7:0]  status;
   logic        thi_wr;
   logic        wrap;

   assign sel    = (address[15:4] == BASE_ADDR[15:4]);
   assign off    = address[3:0];
   assign bus_wr = sel & ~read_en;
   assign bus_rd = sel & read_en;

   assign hit_data   = (off == OFF_DATA);
   assign hit_status = (off == OFF_STATUS);
   assign hit_ctrl   = (off == OFF_CTRL);
   assign hit_tlo    = (off == OFF_TLO);
   assign hit_thi    = (off == OFF_THI);

   // full is judged before the edge, so a same-cycle pop never rescues a push
   assign push_req = bus_wr & hit_data;
   assign push     = push_req & ~tx_full;
   assign pop      = tx_valid & tx_ready;
   assign tx_valid = ~tx_empty;
   assign rx_ready = ~rx_full;

   io_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (ph2),
      .rst   (reset),
      .push  (push),
      .pop   (pop),
      .din   (wdata),
      .head  (tx_data),
      .full  (tx_full),
      .empty (tx_empty)
   );

   assign thi_wr = bus_wr & hit_thi;
   assign wrap   = ctrl.timer_run & (count == '0) & ~thi_wr;

   always_ff @(posedge ph2 or posedge reset) begin
      if (reset) begin
         rx_full <= 1'b0;
         rx_hold <= '0;
      end else if (rx_valid && rx_ready) begin
         rx_full <= 1'b1;
         rx_hold <= rx_data;
      end else if (bus_rd && hit_data) begin
         rx_full <= 1'b0;
      end
   end

   // set beats write-one-to-clear on both sticky flags
   always_ff @(posedge ph2 or posedge reset) begin
      if (reset) begin
         tx_ovf     <= 1'b0;
         timer_flag <= 1'b0;
      end else begin
         if (push_req && tx_full)
            tx_ovf <= 1'b1;
         else if (bus_wr && hit_status && wdata[ST_TX_OVF])
            tx_ovf <= 1'b0;
         if (wrap)
            timer_flag <= 1'b1;
         else if (bus_wr && hit_status && wdata[ST_TIMER])
            timer_flag <= 1'b0;
      end
   end

   always_ff @(posedge ph2 or posedge reset) begin
      if (reset) begin
         ctrl   <= '0;
         reload <= '0;
         count  <= '0;
      end else begin
         if (bus_wr && hit_ctrl) ctrl <= ctrl_t'(wdata[3:0]);
         if (bus_wr && hit_tlo)  reload[7:0] <= wdata;
         if (thi_wr) begin
            reload[15:8] <= wdata;
            count        <= {wdata, reload[7:0]};
         end else if (ctrl.timer_run) begin
            if (count != '0) count <= count - 16'd1;
            else             count <= reload;
         end
      end
   end

   assign irq = (rx_full & ctrl.rx_ie)
              | (tx_empty & ctrl.tx_empty_ie)
              | (timer_flag & ctrl.timer_ie);

   always_comb begin
      status              = '0;
      status[ST_TX_FULL]  = tx_full;
      status[ST_TX_EMPTY] = tx_empty;
      status[ST_RX_FULL]  = rx_full;
      status[ST_TX_OVF]   = tx_ovf;
      status[ST_TIMER]    = timer_flag;
      status[ST_IRQ]      = irq;
   end

   always_comb begin
      rdata = '0;
      if (bus_rd) begin
         unique case (1'b1)
            hit_data:   rdata = rx_hold;
            hit_status: rdata = status;
            hit_ctrl:   rdata = {4'b0, ctrl};
            hit_tlo:    rdata = count[7:0];
            hit_thi:    rdata = count[15:8];
            default:    rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_io_responder.sv
// Randomized and directed bench for io_responder against a
// queue-based reference model of the register map.
module tb_io_responder;

   localparam int DEPTH = 4;

   logic        ph2 = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] address = '0;
   logic        read_en = 1'b1;
   logic [7:0]  wdata = '0;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rdata;
   logic        sel;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        rx_ready;
   logic        irq;

   io_responder dut (
      .ph2      (ph2),
      .reset    (reset),
      .address  (address),
      .read_en  (read_en),
      .wdata    (wdata),
      .rdata    (rdata),
      .sel      (sel),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .irq      (irq)
   );

   always #5 ph2 = ~ph2;

   int checks = 0;
   int failures = 0;

   logic [7:0]  tx_q[$];
   bit          m_rx_full;
   logic [7:0]  m_rx_hold;
   bit          m_ovf;
   bit          m_tflag;
   logic [3:0]  m_ctrl;
   logic [15:0] m_reload;
   logic [15:0] m_count;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      tx_q.delete();
      m_rx_full = 0;
      m_rx_hold = '0;
      m_ovf = 0;
      m_tflag = 0;
      m_ctrl = '0;
      m_reload = '0;
      m_count = '0;
   endtask

   function automatic bit m_irq();
      return (m_rx_full && m_ctrl[0]) ||
             (tx_q.size() == 0 && m_ctrl[1]) ||
             (m_tflag && m_ctrl[2]);
   endfunction

   function automatic logic [7:0] m_rdata(logic [15:0] a, logic rd);
      logic [7:0] r;
      r = '0;
      if (a[15:4] == 12'hF00 && rd) begin
         case (a[3:0])
            4'd0: r = m_rx_hold;
            4'd1: r = {m_irq(), 1'b0, m_tflag, 1'b0, m_ovf, m_rx_full,
                       tx_q.size() == 0, tx_q.size() == DEPTH};
            4'd2: r = {4'b0, m_ctrl};
            4'd3: r = m_count[7:0];
            4'd4: r = m_count[15:8];
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   task automatic model_step(logic [15:0] a, logic rd, logic [7:0] wd,
                             logic txr, logic [7:0] rxd, logic rxv);
      bit s, wr, was_full;
      logic [3:0] o;
      s = (a[15:4] == 12'hF00);
      o = a[3:0];
      wr = s && !rd;
      was_full = (tx_q.size() == DEPTH);
      if (tx_q.size() > 0 && txr) void'(tx_q.pop_front());
      if (wr && o == 4'd1 && wd[3]) m_ovf = 0;
      if (wr && o == 4'd0) begin
         if (was_full) m_ovf = 1;
         else tx_q.push_back(wd);
      end
      if (rxv && !m_rx_full) begin
         m_rx_hold = rxd;
         m_rx_full = 1;
      end else if (s && rd && o == 4'd0) begin
         m_rx_full = 0;
      end
      if (wr && o == 4'd1 && wd[5]) m_tflag = 0;
      if (wr && o == 4'd4) begin
         m_reload[15:8] = wd;
         m_count = {wd, m_reload[7:0]};
      end else if (m_ctrl[3]) begin
         if (m_count != 0) m_count = m_count - 1;
         else begin
            m_count = m_reload;
            m_tflag = 1;
         end
      end
      if (wr && o == 4'd3) m_reload[7:0] = wd;
      if (wr && o == 4'd2) m_ctrl = wd[3:0];
   endtask

   task automatic check_outputs();
      check("sel", sel, address[15:4] == 12'hF00);
      check("rdata", rdata, m_rdata(address, read_en));
      check("tx_valid", tx_valid, tx_q.size() > 0);
      check("tx_data", tx_data, tx_q.size() > 0 ? tx_q[0] : 8'h00);
      check("rx_ready", rx_ready, !m_rx_full);
      check("irq", irq, m_irq());
   endtask

   task automatic cycle(logic [15:0] a, logic rd, logic [7:0] wd,
                        logic txr, logic [7:0] rxd, logic rxv);
      @(negedge ph2);
      address = a;
      read_en = rd;
      wdata = wd;
      tx_ready = txr;
      rx_data = rxd;
      rx_valid = rxv;
      #1;
      check_outputs();
      model_step(a, rd, wd, txr, rxd, rxv);
   endtask

   task automatic bus_wr(logic [15:0] a, logic [7:0] d);
      cycle(a, 1'b0, d, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic bus_rd(logic [15:0] a);
      cycle(a, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic idle(logic txr);
      cycle(16'h0000, 1'b1, 8'h00, txr, 8'h00, 1'b0);
   endtask

   // asserted between edges to exercise the asynchronous path
   task automatic do_reset();
      @(posedge ph2);
      #2;
      address = 16'h0000;
      read_en = 1'b1;
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_rx_ready", rx_ready, 1);
      check("rst_irq", irq, 0);
      check("rst_rdata", rdata, 0);
      model_reset();
      @(posedge ph2);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_tx [4];
      logic [15:0] a;
      logic [7:0] wd;
      exp_tx[0] = 8'h11;
      exp_tx[1] = 8'h22;
      exp_tx[2] = 8'h33;
      exp_tx[3] = 8'h44;
      model_reset();
      do_reset();

      bus_rd(16'hF001);
      check("status_reset", rdata, 8'h02);

      bus_wr(16'hF000, 8'h11);
      bus_wr(16'hF000, 8'h22);
      bus_wr(16'hF000, 8'h33);
      bus_wr(16'hF000, 8'h44);
      bus_wr(16'hF000, 8'h55);
      bus_rd(16'hF001);
      check("status_full_ovf", rdata, 8'h09);
      for (int i = 0; i < 4; i++) begin
         idle(1'b1);
         check("tx_seq", tx_data, exp_tx[i]);
      end
      idle(1'b1);
      check("tx_drained", tx_valid, 0);

      cycle(16'h0000, 1'b1, 8'h00, 1'b0, 8'hA5, 1'b1);
      bus_rd(16'hF001);
      check("rx_ready_low", rx_ready, 0);
      check("rx_full_bit", rdata[2], 1);
      bus_rd(16'hF000);
      check("rx_byte", rdata, 8'hA5);
      bus_rd(16'hF001);
      check("rx_full_clr", rdata[2], 0);

      bus_wr(16'hF003, 8'h03);
      bus_wr(16'hF004, 8'h00);
      bus_wr(16'hF002, 8'h0C);
      for (int i = 0; i < 8; i++) idle(1'b0);
      check("timer_irq", irq, 1);
      bus_wr(16'hF001, 8'h20);
      for (int i = 0; i < 6; i++) idle(1'b0);

      bus_wr(16'hF002, 8'h02);
      bus_wr(16'hF001, 8'h28);
      idle(1'b0);
      check("txe_irq", irq, 1);
      bus_wr(16'hF000, 8'h77);
      idle(1'b0);
      check("txe_irq_off", irq, 0);

      bus_rd(16'hF010);
      check("out_sel", sel, 0);
      check("out_rdata", rdata, 0);

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 7) == 0) a = 16'($urandom);
         else a = {12'hF00, 4'($urandom_range(0, 7))};
         wd = 8'($urandom);
         if (a[3:0] == 4'd4) wd = 8'($urandom_range(0, 1));
         if (a[3:0] == 4'd3) wd = 8'($urandom_range(0, 7));
         cycle(a, 1'($urandom_range(0, 1)), wd, 1'($urandom_range(0, 1)),
               8'($urandom), 1'($urandom_range(0, 1)));
         if (n == 300) begin
            bus_wr(16'hF000, 8'hC3);
            bus_wr(16'hF000, 8'h3C);
            do_reset();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
